// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   localparam int unsigned DATA_MIN   = 5;
   localparam int unsigned DATA_MAX   = 8;
   localparam int unsigned MIN_PERIOD = 2;
   localparam int unsigned PERIOD_W   = 14;

   // XOR of the first 'size' data bits, inverted for odd parity.
   function automatic logic calc_parity(logic [7:0] data, logic [3:0] size, logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(size)) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period counter: pulses bit_tick_o on the cycle the count reaches limit_i.
module tx_bit_timer
   import uart_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                en_i,
   input  logic [PERIOD_W-1:0] limit_i,
   output logic                bit_tick_o
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;

   assign bit_tick_o = en_i && (cnt_q == limit_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = bit_tick_o ? '0 : cnt_q + 14'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART frame transmitter: start, 5..8 data bits LSB first, optional parity, one stop bit.
module uart_transmitter
   import uart_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                tx_start,
   input  logic [7:0]          tx_data,
   input  logic [PERIOD_W-1:0] bit_period,
   input  logic [3:0]          data_size,
   input  logic                parity_en,
   input  logic                parity_odd,
   output logic                tx_out,
   output logic                tx_busy,
   output logic                tx_done
);

   state_e              state_q, state_d;
   logic [7:0]          data_q, data_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [3:0]          size_q, size_d;
   logic                par_en_q, par_en_d;
   logic                par_odd_q, par_odd_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic                tx_out_q, tx_out_d;
   logic                tx_done_q, tx_done_d;

   logic                bit_tick;
   logic                last_bit;
   logic [PERIOD_W-1:0] tick_limit;

   // Stop lasts one clock short; the tx_done idle cycle completes the stop bit.
   assign tick_limit = (state_q == StStop) ? period_q - 14'd2 : period_q - 14'd1;
   assign last_bit   = (bit_idx_q == 3'(size_q - 4'd1));

   tx_bit_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (state_q == StIdle),
      .en_i       (state_q != StIdle),
      .limit_i    (tick_limit),
      .bit_tick_o (bit_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         data_q    <= '0;
         period_q  <= 14'(MIN_PERIOD);
         size_q    <= 4'(DATA_MAX);
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         bit_idx_q <= '0;
         tx_out_q  <= 1'b1;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         period_q  <= period_d;
         size_q    <= size_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         bit_idx_q <= bit_idx_d;
         tx_out_q  <= tx_out_d;
         tx_done_q <= tx_done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      period_d  = period_q;
      size_d    = size_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         StIdle: begin
            if (tx_start) begin
               state_d   = StStart;
               data_d    = tx_data;
               period_d  = (bit_period < 14'(MIN_PERIOD)) ? 14'(MIN_PERIOD) : bit_period;
               size_d    = (data_size < 4'(DATA_MIN) || data_size > 4'(DATA_MAX)) ?
                           4'(DATA_MAX) : data_size;
               par_en_d  = parity_en;
               par_odd_d = parity_odd;
               bit_idx_d = '0;
            end
         end
         StStart: begin
            if (bit_tick) begin
               state_d   = StData;
               bit_idx_d = '0;
            end
         end
         StData: begin
            if (bit_tick) begin
               if (last_bit) state_d = par_en_q ? StParity : StStop;
               else          bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         StParity: if (bit_tick) state_d = StStop;
         StStop:   if (bit_tick) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      tx_done_d = (state_q == StStop) && bit_tick;
      case (state_d)
         StStart:  tx_out_d = 1'b0;
         StData:   tx_out_d = data_q[bit_idx_d];
         StParity: tx_out_d = calc_parity(data_q, size_q, par_odd_q);
         default:  tx_out_d = 1'b1;
      endcase
   end

   assign tx_out  = tx_out_q;
   assign tx_done = tx_done_q;
   assign tx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with hand-computed serial bit patterns.
module tb_uart_transmitter;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [13:0] bit_period;
   logic [3:0]  data_size;
   logic        parity_en;
   logic        parity_odd;
   logic        tx_out;
   logic        tx_busy;
   logic        tx_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_transmitter dut (
      .clk        (clk),
      .rst        (rst),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .bit_period (bit_period),
      .data_size  (data_size),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .tx_out     (tx_out),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // bits: expected line levels, bit 0 sent first; p: effective clocks per bit.
   task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] sz,
                            input logic [13:0] per, input logic pe, input logic po,
                            input logic [11:0] bits, input int nbits, input int p,
                            input bit poke);
      int len;
      len = nbits * p;
      @(negedge clk);
      tx_data = d; data_size = sz; bit_period = per;
      parity_en = pe; parity_odd = po; tx_start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= len; c++) begin
         @(negedge clk);
         tx_start = 1'b0;
         if (poke && c == 30) begin
            tx_start = 1'b1; tx_data = ~d; bit_period = 14'd3;
            data_size = 4'd5; parity_en = ~pe;
         end
         chk({tag, "_out"}, 32'(tx_out), 32'(bits[(c-1)/p]));
         chk({tag, "_busy"}, 32'(tx_busy), 32'(c < len));
         chk({tag, "_done"}, 32'(tx_done), 32'(c == len));
      end
      tx_start = 1'b0;
   endtask

   task automatic check_idle(input string tag, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         chk({tag, "_out"}, 32'(tx_out), 32'd1);
         chk({tag, "_busy"}, 32'(tx_busy), 32'd0);
         chk({tag, "_done"}, 32'(tx_done), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; tx_start = 1'b0; tx_data = '0; bit_period = 14'd10;
      data_size = 4'd8; parity_en = 1'b0; parity_odd = 1'b0;
      // reset wins over a simultaneous start request
      @(negedge clk); tx_start = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out", 32'(tx_out), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      tx_start = 1'b0; rst = 1'b0;
      check_idle("idle0", 3);

      // 0xA5, 8N1, period 10: 0,1,0,1,0,0,1,0,1,1
      run_frame("a5_8n1", 8'hA5, 4'd8, 14'd10, 1'b0, 1'b0, 12'h34A, 10, 10, 1'b0);
      check_idle("idle1", 2);
      run_frame("a5_even", 8'hA5, 4'd8, 14'd10, 1'b1, 1'b0, 12'h54A, 11, 10, 1'b0);
      run_frame("a5_odd", 8'hA5, 4'd8, 14'd10, 1'b1, 1'b1, 12'h74A, 11, 10, 1'b0);
      check_idle("idle2", 2);
      run_frame("ff_sz5", 8'hFF, 4'd5, 14'd4, 1'b0, 1'b0, 12'h07E, 7, 4, 1'b0);
      run_frame("ff_sz3", 8'hFF, 4'd3, 14'd4, 1'b0, 1'b0, 12'h3FE, 10, 4, 1'b0);
      // period 1 acts as 2; size 6 even parity over 111011
      run_frame("0f_p1", 8'h0F, 4'd8, 14'd1, 1'b1, 1'b1, 12'h61E, 11, 2, 1'b0);
      run_frame("fb_sz6", 8'hFB, 4'd6, 14'd3, 1'b1, 1'b0, 12'h1F6, 9, 3, 1'b0);
      // start pulse and input changes mid-frame have no effect
      run_frame("poke", 8'hA5, 4'd8, 14'd10, 1'b0, 1'b0, 12'h34A, 10, 10, 1'b1);
      check_idle("no_second", 15);

      // reset during DATA
      @(negedge clk);
      tx_data = 8'hA5; data_size = 4'd8; bit_period = 14'd10; parity_en = 1'b0;
      tx_start = 1'b1;
      @(negedge clk); tx_start = 1'b0;
      repeat (25) @(negedge clk);
      chk("pre_rst_busy", 32'(tx_busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_out", 32'(tx_out), 32'd1);
      chk("mid_rst_busy", 32'(tx_busy), 32'd0);
      chk("mid_rst_done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      check_idle("post_rst", 3);
      run_frame("after_rst", 8'hA5, 4'd8, 14'd10, 1'b1, 1'b1, 12'h74A, 11, 10, 1'b0);

      // tx_start held high: frames every 20 clocks
      @(negedge clk);
      tx_data = 8'hA5; data_size = 4'd8; bit_period = 14'd2; parity_en = 1'b0;
      tx_start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 60) tx_start = 1'b0;
         chk("b2b_out", 32'(tx_out), 32'((12'h34A >> (((c - 1) % 20) / 2)) & 12'h1));
         chk("b2b_busy", 32'(tx_busy), 32'((c % 20) != 0));
         chk("b2b_done", 32'(tx_done), 32'((c % 20) == 0));
      end
      check_idle("b2b_end", 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: tx_start  input  1  request to send one frame, sampled only in IDLE.
REQ-004 SHALL have port: tx_data  input  8  payload, LSB transmitted first.
REQ-005 SHALL have port: bit_period  input  14  clocks per serial bit.
REQ-006 SHALL have port: data_size  input  4  data bits per frame, legal 5..8.
REQ-007 SHALL have port: parity_en  input  1  insert parity bit after data.
REQ-008 SHALL have port: parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-009 SHALL have port: tx_out  output  1  serial line, idle high.
REQ-010 SHALL have port: tx_busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port: tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL leave IDLE only on tx_start=1 in IDLE; transition is IDLE->START; tx_busy SHALL be high from the next cycle.
REQ-014 SHALL latch tx_data, bit_period, data_size, parity_en and parity_odd on the accepting cycle; input changes mid-frame SHALL have no effect.
REQ-015 SHALL ignore tx_start while tx_busy=1, with no queuing.
REQ-016 SHALL hold each bit on tx_out for exactly bit_period clocks; latched bit_period values 0 or 1 SHALL be treated as 2.
REQ-017 SHALL clamp latched data_size values below 5 or above 8 to 8.
REQ-018 SHALL drive the START bit as 0.
REQ-019 SHALL drive DATA bits tx_data[0] through tx_data[data_size-1].
REQ-020 SHALL drive the PARITY bit, when parity_en=1, as the XOR of the sent data bits, XORed with parity_odd.
REQ-021 SHALL drive one STOP bit as 1.
REQ-022 SHALL skip the PARITY state when parity_en=0 (DATA->STOP).
REQ-023 SHALL drive tx_out from a register, first changing on the cycle after acceptance, and SHALL never glitch.
REQ-024 SHALL, after the last STOP clock, return to IDLE, pulse tx_done for that first IDLE cycle, and drop tx_busy in the same cycle.
REQ-025 SHALL accept a tx_start asserted in the tx_done cycle, giving back-to-back frames with no extra idle bit.
REQ-026 SHALL have a frame length of (1 + data_size + parity_en + 1) x bit_period clocks.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force state IDLE, tx_out=1, tx_busy=0, tx_done=0 and clear all counters, including mid-frame.
REQ-028 SHALL give rst priority over tx_start in the same cycle.

Structure
REQ-029 SHALL take the state enum and the constants DATA_MIN=5, DATA_MAX=8 and MIN_PERIOD=2 from shared package uart_pkg.
REQ-030 SHALL place bit-period timing in sub-module tx_bit_timer: a 14-bit counter with clear and enable, emitting a one-cycle bit_tick at each bit boundary; the bit index counter stays in the top level.

Verification
REQ-031 SHALL cover: bit_period=10, data_size=8, parity_en=0, tx_data=0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 with each level held 10 clocks; tx_done 100 clocks after acceptance.
REQ-032 SHALL cover: same frame with parity_en=1, parity_odd=0 -> parity bit 0; with parity_odd=1 -> parity bit 1; frame length 110 clocks.
REQ-033 SHALL cover: data_size=5, tx_data=0xFF, bit_period=4 -> 5 data ones then stop; frame 28 clocks; data_size=3 -> behaves as 8 (40 clocks).
REQ-034 SHALL cover: tx_start pulsed at clock 30 of a frame with a different tx_data -> current frame unchanged and no second frame sent.
REQ-035 SHALL cover: rst asserted during DATA -> next cycle tx_out=1, tx_busy=0, tx_done=0, and a subsequent frame is correct.
REQ-036 SHALL cover: tx_start held high continuously with bit_period=2, data_size=8 -> back-to-back frames every 20 clocks, tx_done pulsing once per frame.
